ahb_mem_slave_glue: RTL and testbench
=====================================

# ahb_mem_slave_glue

Parametrised AHB-Lite slave front end placed between the bus interconnect and the on-chip ROM/RAM macros. It is the pipelined successor of the combinational ROM/RAM glue.
- Splits every transfer into a registered address phase and a data phase.
- Decodes two configurable regions and applies per-region wait states.
- Generates RAM byte strobes from hsize/haddr.
- Returns the AHB two-cycle ERROR response for illegal transfers.

## Interface
Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width. Legal values are 32 and 64. STRB_W = DATA_W/8.
- ROM_BASE, 32'hA000_0000: ROM region base.
- ROM_MASK, 32'hFF00_0000: ROM region mask.
- RAM_BASE, 32'h2000_0000: RAM region base.
- RAM_MASK, 32'hFF00_0000: RAM region mask.
- ROM_WAIT, 1: wait states per ROM read, range 0-7.
- RAM_WAIT, 0: wait states per RAM transfer, range 0-7.

Ports:
- hclk  in  1  clock. All logic is rising-edge.
- hreset  in  1  asynchronous reset, active-high.
- hsel  in  1  slave select.
- haddr  in  ADDR_W  address.
- htrans  in  2  transfer type. htrans[1]=1 means NONSEQ/SEQ.
- hwrite  in  1  write when 1.
- hsize  in  3  transfer size.
- hprot  in  4  protection. Not decoded.
- hwdata  in  DATA_W  write data, valid in the data phase.
- hready  in  1  global bus ready.
- hreadyout  out  1  slave ready.
- hresp  out  1  1 = ERROR.
- hrdata  out  DATA_W  read data.
- rom_rd_en  out  1  ROM read strobe.
- rom_addr  out  ADDR_W  ROM read address.
- rom_rdata  in  DATA_W  ROM data.
- ram_rd_en  out  1  RAM read strobe.
- ram_raddr  out  ADDR_W  RAM read address.
- ram_rdata  in  DATA_W  RAM data.
- ram_wr_en  out  1  RAM write strobe.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_wstrb  out  STRB_W  RAM byte enables.

## Operation
- **Accept condition:** a transfer is accepted when hsel & hready & htrans[1] & hreadyout. Otherwise it is an IDLE/BUSY or unselected cycle: no enables fire and the response is zero-wait OKAY.
- **Region decode:** ROM hit is (haddr & ROM_MASK) == ROM_BASE. RAM hit is the same test with the RAM parameters. ROM wins when both hit.
- **Illegal transfers** get ERROR and fire no memory enable:
  - neither region hits;
  - ROM write;
  - 8 << hsize > DATA_W;
  - haddr not aligned to 2^hsize.
- **Reads (legal):** combinational in the address phase. rom_rd_en or ram_rd_en = 1 for that cycle only. rom_addr / ram_raddr = haddr; both hold haddr at all other times.
- **Memory read contract:** each memory returns data on the next hclk edge and holds it until its next rd_en.
- **Writes:** address, size and region are registered at acceptance. ram_wr_en pulses in the first data-phase cycle, with:
  - ram_waddr = registered address;
  - ram_wdata = hwdata;
  - ram_wstrb = 2^hsize ones, shifted by haddr[log2(STRB_W)-1:0].
- **hrdata:** rom_rdata or ram_rdata, selected by the registered region, during a read data phase. It is 0 in every other cycle.
- **FSM states:**
  - **IDLE:** no data phase. hreadyout=1, hresp=0.
  - **DATA:** the wait counter is loaded with the region's wait count (ROM_WAIT or RAM_WAIT) at acceptance. hreadyout=0 while the counter is non-zero, decrementing each cycle. When the counter reaches 0: hreadyout=1, go to IDLE, or stay in DATA if a new transfer is accepted.
  - **ERR1:** hreadyout=0, hresp=1. Always goes to ERR2.
  - **ERR2:** hreadyout=1, hresp=1. Goes to IDLE, or to DATA/ERR1 if a new transfer is accepted this cycle.
  - **HAZ:** hreadyout=0, hresp=0. Always goes to IDLE next cycle.
- **Read-after-write hazard:** only possible when RAM_WAIT=0. Condition: in the cycle ram_wr_en fires, a RAM read address phase is presented whose haddr word equals ram_waddr's word. Response:
  - the read is not accepted; its rd_en is suppressed;
  - the glue enters HAZ for one cycle, extending the write data phase by one wait;
  - the master re-presents the read, which is accepted next cycle and returns the new data.

## Timing
- **Reset values:** hreadyout=1, hresp=0, hrdata=0, all *_en=0, ram_wstrb=0, ram_wdata=0, ram_waddr=0, state IDLE, wait counter 0. rom_addr/ram_raddr follow haddr.
- **Reset mid-transfer:** the FSM returns to IDLE immediately. No further ram_wr_en fires for the aborted transfer.
- **Read latency:** data-phase length is 1 + wait count cycles. hrdata is valid in the cycle hreadyout=1.
- **Write latency:** ram_wr_en fires exactly once, in data cycle 1, regardless of wait count.
- **Error:** exactly 2 data-phase cycles. hresp=1 in both.
- **Back-to-back:** a transfer accepted in the last cycle of a data phase starts its own data phase next cycle, with no bubble.

## Test plan
- **ROM read, ROM_WAIT=1:** haddr=A000_0010 read. Expect rom_rd_en=1 in the address cycle, hreadyout=0 then 1, and hrdata=rom_rdata in the second data cycle.
- **RAM byte write:** haddr=2000_0003, hsize=0, hwdata=AABBCCDD. Expect ram_wr_en=1 one cycle, ram_wstrb=4'b1000, ram_waddr=2000_0003.
- **Illegal transfers:** ROM write to A000_0000, then a read of 3000_0000. Each gives hreadyout 0/1 with hresp 1/1, and no enables fire.
- **Misaligned word read:** haddr=2000_0002, hsize=2. Expect the two-cycle ERROR and ram_rd_en=0.
- **Hazard:** write to 2000_0040 followed immediately by a read of 2000_0040 (RAM_WAIT=0). Expect one HAZ cycle with hreadyout=0 and ram_rd_en low. The re-presented read then returns the written data.
- **Reset abort:** hreset asserted during a ROM data phase with a 3-cycle wait. Expect hreadyout=1 immediately, hresp=0, and no later enable.

Source files
------------

// File: rtl/ahb_mem_slave_glue.sv
// AHB-Lite slave front end for the on-chip ROM/RAM macros: registered address
// phase, per-region wait states, byte strobes, two-cycle ERROR and RAW stall.
module ahb_mem_slave_glue #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] ROM_BASE = 32'hA000_0000,
    parameter logic [ADDR_W-1:0] ROM_MASK = 32'hFF00_0000,
    parameter logic [ADDR_W-1:0] RAM_BASE = 32'h2000_0000,
    parameter logic [ADDR_W-1:0] RAM_MASK = 32'hFF00_0000,
    parameter int              ROM_WAIT = 1,
    parameter int              RAM_WAIT = 0
) (
    input  logic                hclk,
    input  logic                hreset,
    input  logic                hsel,
    input  logic [ADDR_W-1:0]   haddr,
    input  logic [1:0]          htrans,
    input  logic                hwrite,
    input  logic [2:0]          hsize,
    input  logic [3:0]          hprot,
    input  logic [DATA_W-1:0]   hwdata,
    input  logic                hready,
    output logic                hreadyout,
    output logic                hresp,
    output logic [DATA_W-1:0]   hrdata,
    output logic                rom_rd_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_rdata,
    output logic                ram_rd_en,
    output logic [ADDR_W-1:0]   ram_raddr,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                ram_wr_en,
    output logic [ADDR_W-1:0]   ram_waddr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_wstrb
);
    localparam int         STRB_W   = DATA_W / 8;
    localparam int         LSB      = $clog2(STRB_W);
    localparam logic [2:0] MAX_SIZE = 3'(LSB);
    localparam logic       HAZ_EN   = (RAM_WAIT == 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_ERR1 = 3'd2;
    localparam logic [2:0] S_ERR2 = 3'd3;
    localparam logic [2:0] S_HAZ  = 3'd4;

    logic [2:0]        state;
    logic [2:0]        cnt;
    logic              first;
    logic              d_rom;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [STRB_W-1:0] d_strb;

    logic              rom_hit, ram_hit, size_bad, misalign, illegal;
    logic              accept, acc_ok, acc_err, wr_fire, haz;
    logic [ADDR_W-1:0] align_mask;
    logic [STRB_W-1:0] strb;
    logic [2:0]        wload;
    logic              unused_ok;

    assign unused_ok = &{1'b0, hprot, htrans[0]};

    assign rom_hit    = (haddr & ROM_MASK) == ROM_BASE;
    assign ram_hit    = (haddr & RAM_MASK) == RAM_BASE;
    assign size_bad   = hsize > MAX_SIZE;
    assign align_mask = ~({ADDR_W{1'b1}} << hsize);
    assign misalign   = |(haddr & align_mask);
    assign illegal    = !(rom_hit || ram_hit) || (rom_hit && hwrite) || size_bad || misalign;

    assign accept  = hsel && hready && htrans[1] && hreadyout;
    assign wr_fire = (state == S_DATA) && d_write && first;

    // A same-word RAM read arriving while the write lands would see stale data;
    // refuse it and stall one cycle so the master re-presents it after the write.
    assign haz = HAZ_EN && wr_fire && accept && !hwrite && !illegal && !rom_hit &&
                 (haddr[ADDR_W-1:LSB] == d_addr[ADDR_W-1:LSB]);

    assign acc_ok  = accept && !illegal && !haz;
    assign acc_err = accept && illegal;
    assign wload   = rom_hit ? 3'(ROM_WAIT) : 3'(RAM_WAIT);

    always_comb begin
        strb = '0;
        for (int i = 0; i < STRB_W; i++)
            if (i >= int'(haddr[LSB-1:0]) && i < int'(haddr[LSB-1:0]) + (1 << hsize))
                strb[i] = 1'b1;
    end

    assign rom_rd_en = acc_ok && !hwrite && rom_hit;
    assign ram_rd_en = acc_ok && !hwrite && !rom_hit;
    assign rom_addr  = haddr;
    assign ram_raddr = haddr;

    assign ram_wr_en = wr_fire;
    assign ram_waddr = d_addr;
    assign ram_wdata = wr_fire ? hwdata : '0;
    assign ram_wstrb = wr_fire ? d_strb : '0;

    assign hrdata = (state == S_DATA && !d_write) ? (d_rom ? rom_rdata : ram_rdata) : '0;
    assign hresp  = (state == S_ERR1) || (state == S_ERR2);

    always_comb begin
        case (state)
            S_DATA:        hreadyout = (cnt == 3'd0);
            S_ERR1, S_HAZ: hreadyout = 1'b0;
            default:       hreadyout = 1'b1;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            first   <= 1'b0;
            d_rom   <= 1'b0;
            d_write <= 1'b0;
            d_addr  <= '0;
            d_strb  <= '0;
        end else begin
            first <= 1'b0;
            case (state)
                S_DATA: begin
                    if (cnt != 3'd0)  cnt   <= 3'(cnt - 3'd1);
                    else if (haz)     state <= S_HAZ;
                    else if (acc_err) state <= S_ERR1;
                    else if (acc_ok)  state <= S_DATA;
                    else              state <= S_IDLE;
                end
                S_ERR1: state <= S_ERR2;
                S_HAZ:  state <= S_IDLE;
                default: begin
                    if (acc_err)     state <= S_ERR1;
                    else if (acc_ok) state <= S_DATA;
                    else             state <= S_IDLE;
                end
            endcase
            // acc_ok only occurs when hreadyout=1, so it never races the decrement.
            if (acc_ok) begin
                d_addr  <= haddr;
                d_strb  <= strb;
                d_rom   <= rom_hit;
                d_write <= hwrite;
                cnt     <= wload;
                first   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ahb_mem_slave_glue.sv
// Directed bench: default glue (ROM_WAIT=1, RAM_WAIT=0) plus a ROM_WAIT=3 copy
// for the reset-abort case, with simple ROM/RAM behavioural models.
module tb_ahb_mem_slave_glue;
    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] rom_rdata = '0;
    logic [31:0] ram_rdata = '0;

    logic        hreadyout, hresp, rom_rd_en, ram_rd_en, ram_wr_en;
    logic [31:0] hrdata, rom_addr, ram_raddr, ram_waddr, ram_wdata;
    logic [3:0]  ram_wstrb;

    logic        hreadyout3, hresp3, rom_rd_en3, ram_rd_en3, ram_wr_en3;
    logic [31:0] hrdata3, rom_addr3, ram_raddr3, ram_waddr3, ram_wdata3;
    logic [3:0]  ram_wstrb3;

    logic [31:0] mem [64];
    int n_run  = 0;
    int n_fail = 0;

    always #5 hclk = ~hclk;

    ahb_mem_slave_glue u_dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .ram_rd_en(ram_rd_en), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .ram_wr_en(ram_wr_en), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb)
    );

    ahb_mem_slave_glue #(.ROM_WAIT(3)) u_dut3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout3), .hresp(hresp3), .hrdata(hrdata3),
        .rom_rd_en(rom_rd_en3), .rom_addr(rom_addr3), .rom_rdata(rom_rdata),
        .ram_rd_en(ram_rd_en3), .ram_raddr(ram_raddr3), .ram_rdata(ram_rdata),
        .ram_wr_en(ram_wr_en3), .ram_waddr(ram_waddr3), .ram_wdata(ram_wdata3),
        .ram_wstrb(ram_wstrb3)
    );

    // Memory models: data appears on the edge after rd_en and holds.
    always @(posedge hclk) begin
        if (ram_wr_en)
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) mem[ram_waddr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_rd_en) ram_rdata <= mem[ram_raddr[7:2]];
        if (rom_rd_en) rom_rdata <= rom_addr ^ 32'h5A5A_0000;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic mid();
        @(negedge hclk);
    endtask

    task automatic drv(input logic wr, input logic [2:0] sz, input logic [31:0] a);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic idle();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        hreset = 1'b1; hready = 1'b1; hprot = 4'h3; hwdata = '0;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h1234_5678;

        // Reset state
        mid();
        chk("rst_hreadyout", hreadyout, 1);
        chk("rst_hresp", hresp, 0);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_en", {rom_rd_en, ram_rd_en, ram_wr_en}, 0);
        chk("rst_wstrb", ram_wstrb, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_waddr", ram_waddr, 0);
        chk("rst_rom_addr", rom_addr, 32'h1234_5678);
        chk("rst_ram_raddr", ram_raddr, 32'h1234_5678);
        cyc();
        hreset = 1'b0;
        cyc();

        // ROM read with one wait state
        drv(0, 3'd2, 32'hA000_0010);
        mid();
        chk("rom_rd_en_addr", rom_rd_en, 1);
        chk("rom_ram_rd_en", ram_rd_en, 0);
        cyc(); idle();
        mid();
        chk("rom_wait_ready", hreadyout, 0);
        chk("rom_rd_en_wait", rom_rd_en, 0);
        cyc();
        mid();
        chk("rom_done_ready", hreadyout, 1);
        chk("rom_hrdata", hrdata, 32'hFA5A_0010);
        chk("rom_hresp", hresp, 0);
        cyc();
        mid();
        chk("rom_hrdata_idle", hrdata, 0);

        // RAM byte write
        cyc();
        drv(1, 3'd0, 32'h2000_0003);
        mid();
        chk("wb_no_early_wr", ram_wr_en, 0);
        cyc(); idle(); hwdata = 32'hAABB_CCDD;
        mid();
        chk("wb_wr_en", ram_wr_en, 1);
        chk("wb_wstrb", ram_wstrb, 4'b1000);
        chk("wb_waddr", ram_waddr, 32'h2000_0003);
        chk("wb_wdata", ram_wdata, 32'hAABB_CCDD);
        chk("wb_ready", hreadyout, 1);
        cyc();
        mid();
        chk("wb_wr_once", ram_wr_en, 0);
        chk("wb_wstrb_off", ram_wstrb, 0);

        // RAM halfword write to upper half of word 1
        cyc();
        drv(1, 3'd1, 32'h2000_0006);
        cyc(); idle(); hwdata = 32'h1122_3344;
        mid();
        chk("wh_wstrb", ram_wstrb, 4'b1100);
        cyc();

        // Back-to-back RAM reads, no bubble
        drv(0, 3'd2, 32'h2000_0000);
        mid();
        chk("b2b_rd_en0", ram_rd_en, 1);
        cyc();
        drv(0, 3'd2, 32'h2000_0004);
        mid();
        chk("b2b_rd_en1", ram_rd_en, 1);
        chk("b2b_ready0", hreadyout, 1);
        chk("b2b_hrdata0", hrdata, 32'hAA00_0000);
        cyc(); idle();
        mid();
        chk("b2b_hrdata1", hrdata, 32'h1122_0000);
        cyc();

        // ROM write, then an unmapped read presented in ERR2
        drv(1, 3'd2, 32'hA000_0000);
        mid();
        chk("romwr_no_en", {rom_rd_en, ram_rd_en, ram_wr_en}, 0);
        cyc(); idle();
        mid();
        chk("romwr_err1", {hreadyout, hresp}, 2'b01);
        chk("romwr_no_wr", ram_wr_en, 0);
        cyc();
        drv(0, 3'd2, 32'h3000_0000);
        mid();
        chk("romwr_err2", {hreadyout, hresp}, 2'b11);
        chk("unmap_no_en", {rom_rd_en, ram_rd_en}, 0);
        cyc(); idle();
        mid();
        chk("unmap_err1", {hreadyout, hresp}, 2'b01);
        cyc();
        mid();
        chk("unmap_err2", {hreadyout, hresp}, 2'b11);
        cyc();
        mid();
        chk("unmap_after", {hreadyout, hresp}, 2'b10);

        // Misaligned word read
        cyc();
        drv(0, 3'd2, 32'h2000_0002);
        mid();
        chk("mis_no_rd", ram_rd_en, 0);
        cyc(); idle();
        mid();
        chk("mis_err1", {hreadyout, hresp}, 2'b01);
        cyc();
        mid();
        chk("mis_err2", {hreadyout, hresp}, 2'b11);
        cyc();

        // Doubleword on a 32-bit bus
        drv(0, 3'd3, 32'h2000_0000);
        mid();
        chk("big_no_rd", ram_rd_en, 0);
        cyc(); idle();
        mid();
        chk("big_err1", {hreadyout, hresp}, 2'b01);
        cyc(); cyc();

        // Read-after-write hazard
        drv(1, 3'd2, 32'h2000_0040);
        cyc();
        drv(0, 3'd2, 32'h2000_0040); hwdata = 32'hDEAD_BEEF;
        mid();
        chk("haz_wr_en", ram_wr_en, 1);
        chk("haz_rd_supp", ram_rd_en, 0);
        cyc();
        mid();
        chk("haz_stall", {hreadyout, hresp}, 2'b00);
        chk("haz_rd_low", ram_rd_en, 0);
        chk("haz_no_wr", ram_wr_en, 0);
        cyc();
        mid();
        chk("haz_retry_rd", ram_rd_en, 1);
        cyc(); idle();
        mid();
        chk("haz_ready", hreadyout, 1);
        chk("haz_hrdata", hrdata, 32'hDEAD_BEEF);
        cyc();

        // Reset in the middle of a 3-wait ROM data phase
        hreset = 1'b1;
        cyc();
        hreset = 1'b0;
        cyc();
        drv(0, 3'd2, 32'hA000_0020);
        mid();
        chk("abort_rom_rd", rom_rd_en3, 1);
        cyc(); idle();
        mid();
        chk("abort_wait", hreadyout3, 0);
        cyc();
        hreset = 1'b1;
        #1;
        chk("abort_ready", hreadyout3, 1);
        chk("abort_hresp", hresp3, 0);
        chk("abort_hrdata", hrdata3, 0);
        cyc();
        hreset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("abort_idle_ready", hreadyout3, 1);
            chk("abort_no_en", {rom_rd_en3, ram_rd_en3, ram_wr_en3}, 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
